// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the MEM-stage data-memory access unit.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int DEF_TIMEOUT_CYCLES = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Command fields captured at issue and reused on the return path.
  typedef struct packed {
    logic       we;
    logic [1:0] size;
    logic       zero_ext;
    logic [1:0] offset;
  } cmd_t;

  // Size 2'b11 is handled as a word access.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SZ_BYTE: return 1'b1;
      SZ_HALF: return ~offset[0];
      default: return (offset == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-enable generation, store lane replication and load extract/extension.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        zero_ext,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] raw_rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    case (offset)
      2'd0:    byte_val = raw_rdata[7:0];
      2'd1:    byte_val = raw_rdata[15:8];
      2'd2:    byte_val = raw_rdata[23:16];
      default: byte_val = raw_rdata[31:24];
    endcase
    half_val = offset[1] ? raw_rdata[31:16] : raw_rdata[15:0];
  end

  always_comb begin
    be         = 4'b1111;
    wdata_lane = wdata;
    rdata_ext  = raw_rdata;
    case (size)
      SZ_BYTE: begin
        be         = 4'b0001 << offset;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = {{24{~zero_ext & byte_val[7]}}, byte_val};
      end
      SZ_HALF: begin
        be         = offset[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = {{16{~zero_ext & half_val[15]}}, half_val};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage load/store engine for a variable-latency data-RAM bus.
// Optional bus watchdog enabled by defining DMEM_TIMEOUT_EN.
module dmem_access_unit
  import dmem_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_en,
  input  logic              mem_we,
  input  logic [1:0]        mem_size,
  input  logic              mem_unsigned,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  output logic              addr_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              bus_err
);

  if (DATA_W != 32) begin : g_bad_data_w
    $error("dmem_access_unit: DATA_W must be 32");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("dmem_access_unit: TIMEOUT_CYCLES must be at least 1");
  end

  state_t      state, state_nxt;
  cmd_t        cmd;
  logic        aligned;
  logic        accept;
  logic        timeout_hit;
  logic [1:0]  align_size;
  logic        align_zext;
  logic [1:0]  align_off;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;

  assign aligned = is_aligned(mem_size, addr[1:0]);
  assign bus_we  = cmd.we;

  // One aligner serves both paths: live inputs while issuing from IDLE,
  // the latched command while the transfer is outstanding.
  assign align_size = (state == IDLE) ? mem_size     : cmd.size;
  assign align_zext = (state == IDLE) ? mem_unsigned : cmd.zero_ext;
  assign align_off  = (state == IDLE) ? addr[1:0]    : cmd.offset;

  dmem_lane_align u_lane_align (
    .size      (align_size),
    .zero_ext  (align_zext),
    .offset    (align_off),
    .wdata     (wdata),
    .raw_rdata (bus_rdata),
    .be        (lane_be),
    .wdata_lane(lane_wdata),
    .rdata_ext (lane_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = REQ;
      REQ:     if (bus_ack || timeout_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    accept   = 1'b0;
    stall    = 1'b0;
    bus_req  = 1'b0;
    addr_err = 1'b0;
    case (state)
      IDLE: begin
        accept   = mem_en && aligned;
        stall    = accept;
        addr_err = mem_en && !aligned;
      end
      REQ: begin
        stall   = 1'b1;
        bus_req = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd       <= '0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      rdata     <= '0;
    end else begin
      if (accept) begin
        cmd       <= '{we: mem_we, size: mem_size, zero_ext: mem_unsigned, offset: addr[1:0]};
        bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
        bus_be    <= lane_be;
        bus_wdata <= lane_wdata;
      end
      if (state == REQ) begin
        if (bus_ack)          rdata <= cmd.we ? '0 : lane_rdata;
        else if (timeout_hit) rdata <= '0;
      end
    end
  end

`ifdef DMEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt;

  // Counter holds (REQ cycles seen - 1), so the limit fires on REQ cycle TIMEOUT_CYCLES.
  assign timeout_hit = (state == REQ) && (wait_cnt == CNT_LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
      bus_err  <= 1'b0;
    end else begin
      if (accept)                          wait_cnt <= '0;
      else if ((state == REQ) && !bus_ack) wait_cnt <= wait_cnt + CNT_W'(1);
      bus_err <= timeout_hit && !bus_ack;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign bus_err     = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed self-checking bench for dmem_access_unit (timeout cases need DMEM_TIMEOUT_EN).
module tb_dmem_access_unit;

  logic        clk;
  logic        rst;
  logic        mem_en;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        addr_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_err;

  int          total;
  int          bad;
  int          stalls;
  int          stable_bad;
  logic [3:0]  obs_be;
  logic [31:0] obs_addr;
  logic [31:0] obs_wdata;
  logic        obs_we;

  dmem_access_unit #(
    .ADDR_W        (32),
    .DATA_W        (32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_size    (mem_size),
    .mem_unsigned(mem_unsigned),
    .addr        (addr),
    .wdata       (wdata),
    .rdata       (rdata),
    .stall       (stall),
    .addr_err    (addr_err),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_be      (bus_be),
    .bus_wdata   (bus_wdata),
    .bus_ack     (bus_ack),
    .bus_rdata   (bus_rdata),
    .bus_err     (bus_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, obs=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one access from IDLE and runs until stall drops; returns in the DONE cycle.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                       input int waits);
    int reqs;
    reqs       = 0;
    stalls     = 0;
    stable_bad = 0;
    obs_be     = 'x;
    obs_addr   = 'x;
    obs_wdata  = 'x;
    obs_we     = 1'bx;
    mem_en = 1'b1; mem_we = we; mem_size = size; mem_unsigned = uns;
    addr = a; wdata = wd; bus_ack = 1'b0;
    for (int i = 0; i < 64; i++) begin
      #1;
      if (!stall) break;
      stalls++;
      if (bus_req) begin
        if (reqs == 0) begin
          obs_be = bus_be; obs_addr = bus_addr; obs_wdata = bus_wdata; obs_we = bus_we;
        end else if (bus_be !== obs_be || bus_addr !== obs_addr ||
                     bus_wdata !== obs_wdata || bus_we !== obs_we) begin
          stable_bad++;
        end
        if (reqs == waits) begin
          bus_ack   = 1'b1;
          bus_rdata = rd;
        end
        reqs++;
      end
      tick();
      // The stalled pipeline may present garbage; the latched command must be used.
      mem_en = 1'b0; addr = ~a; wdata = ~wd; bus_ack = 1'b0;
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b0; mem_en = 1'b0; mem_we = 1'b0; mem_size = 2'b00; mem_unsigned = 1'b0;
    addr = '0; wdata = '0; bus_ack = 1'b0; bus_rdata = '0;
    tick(); tick();
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_bus_req", 32'(bus_req), 32'h0);
    chk("rst_bus_be", 32'(bus_be), 32'h0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_bus_wdata", bus_wdata, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_addr_err", 32'(addr_err), 32'h0);
    chk("rst_bus_err", 32'(bus_err), 32'h0);
    rst = 1'b1;
    tick();

    // SW 0x100, ack in first REQ cycle
    issue(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 0);
    chk("sw_stalls", 32'(stalls), 32'd2);
    chk("sw_be", 32'(obs_be), 32'hF);
    chk("sw_addr", obs_addr, 32'h100);
    chk("sw_wdata", obs_wdata, 32'hDEADBEEF);
    chk("sw_we", 32'(obs_we), 32'h1);
    chk("sw_rdata", rdata, 32'h0);
    chk("sw_done_req", 32'(bus_req), 32'h0);
    tick();

    // SB 0x203 replicates byte into all lanes
    issue(1'b1, 2'b00, 1'b0, 32'h203, 32'h000000A5, 32'h0, 0);
    chk("sb_be", 32'(obs_be), 32'h8);
    chk("sb_wdata", obs_wdata, 32'hA5A5A5A5);
    chk("sb_addr", obs_addr, 32'h200);
    chk("sb_stable", 32'(stable_bad), 32'h0);
    tick();

    issue(1'b0, 2'b00, 1'b0, 32'h203, 32'h0, 32'h80FFFFFF, 0);
    chk("lb_rdata", rdata, 32'hFFFFFF80);
    chk("lb_we", 32'(obs_we), 32'h0);
    chk("lb_be", 32'(obs_be), 32'h8);
    tick();

    issue(1'b0, 2'b00, 1'b1, 32'h203, 32'h0, 32'h80FFFFFF, 0);
    chk("lbu_rdata", rdata, 32'h00000080);
    tick();

    // LH 0x102 with three wait cycles
    issue(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 32'h80011234, 3);
    chk("lh_stalls", 32'(stalls), 32'd5);
    chk("lh_rdata", rdata, 32'hFFFF8001);
    chk("lh_be", 32'(obs_be), 32'hC);
    chk("lh_stable", 32'(stable_bad), 32'h0);
    tick();

    issue(1'b0, 2'b01, 1'b1, 32'h100, 32'h0, 32'h80011234, 1);
    chk("lhu_stalls", 32'(stalls), 32'd3);
    chk("lhu_rdata", rdata, 32'h00001234);
    chk("lhu_be", 32'(obs_be), 32'h3);
    tick();

    issue(1'b1, 2'b01, 1'b0, 32'h102, 32'h0000BEEF, 32'h0, 0);
    chk("sh_be", 32'(obs_be), 32'hC);
    chk("sh_wdata", obs_wdata, 32'hBEEFBEEF);
    tick();

    issue(1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 32'h00007F00, 0);
    chk("lb_pos_rdata", rdata, 32'h0000007F);
    chk("lb_pos_be", 32'(obs_be), 32'h2);
    tick();

    // size 2'b11 behaves as a word
    issue(1'b0, 2'b11, 1'b0, 32'h104, 32'h0, 32'hCAFEF00D, 0);
    chk("sz11_rdata", rdata, 32'hCAFEF00D);
    chk("sz11_be", 32'(obs_be), 32'hF);
    tick();

    // Misaligned word and half
    mem_en = 1'b1; mem_we = 1'b0; mem_size = 2'b10; addr = 32'h101;
    #1;
    chk("mis_w_err", 32'(addr_err), 32'h1);
    chk("mis_w_stall", 32'(stall), 32'h0);
    chk("mis_w_req", 32'(bus_req), 32'h0);
    tick();
    mem_en = 1'b0;
    #1;
    chk("mis_w_err_end", 32'(addr_err), 32'h0);
    tick();
    chk("mis_w_req_after", 32'(bus_req), 32'h0);
    mem_en = 1'b1; mem_size = 2'b01; addr = 32'h103;
    #1;
    chk("mis_h_err", 32'(addr_err), 32'h1);
    chk("mis_h_stall", 32'(stall), 32'h0);
    tick();
    mem_en = 1'b0;
    tick();
    chk("mis_h_req_after", 32'(bus_req), 32'h0);

    // Reset mid-REQ, then a stray ack
    mem_en = 1'b1; mem_we = 1'b0; mem_size = 2'b10; mem_unsigned = 1'b0; addr = 32'h300;
    tick();
    mem_en = 1'b0;
    #1;
    chk("mid_req_active", 32'(bus_req), 32'h1);
    rst = 1'b0;
    #1;
    chk("mid_rst_req", 32'(bus_req), 32'h0);
    chk("mid_rst_be", 32'(bus_be), 32'h0);
    chk("mid_rst_addr", bus_addr, 32'h0);
    chk("mid_rst_wdata", bus_wdata, 32'h0);
    chk("mid_rst_rdata", rdata, 32'h0);
    chk("mid_rst_stall", 32'(stall), 32'h0);
    tick();
    rst = 1'b1;
    bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
    tick(); tick();
    chk("late_ack_req", 32'(bus_req), 32'h0);
    chk("late_ack_stall", 32'(stall), 32'h0);
    chk("late_ack_rdata", rdata, 32'h0);
    bus_ack = 1'b0;
    tick();
    issue(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 32'h12345678, 1);
    chk("post_rst_stalls", 32'(stalls), 32'd3);
    chk("post_rst_rdata", rdata, 32'h12345678);
    chk("post_rst_addr", obs_addr, 32'h300);
    chk("bus_err_idle", 32'(bus_err), 32'h0);
    tick();

`ifdef DMEM_TIMEOUT_EN
    issue(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 32'hAAAAAAAA, 100);
    chk("to_stalls", 32'(stalls), 32'd5);
    chk("to_bus_err", 32'(bus_err), 32'h1);
    chk("to_rdata", rdata, 32'h0);
    chk("to_req", 32'(bus_req), 32'h0);
    tick();
    chk("to_bus_err_pulse", 32'(bus_err), 32'h0);

    // ack on the limit cycle completes normally
    issue(1'b0, 2'b10, 1'b0, 32'h404, 32'h0, 32'h55AA55AA, 3);
    chk("to_race_stalls", 32'(stalls), 32'd5);
    chk("to_race_bus_err", 32'(bus_err), 32'h0);
    chk("to_race_rdata", rdata, 32'h55AA55AA);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
